// File: rtl/rnn_out_reader_if.sv
// rtl/rnn_out_reader_if.sv - RNN serial output channel plus word-level read port.
interface rnn_out_reader_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             OUT_REQ;
  logic             OUT_ACK;
  logic             OUT_DATA;
  logic [WIDTH-1:0] RD_DATA;
  logic             RD_VALID;
  logic             RD_READY;
  logic             BUSY;
  logic             TIMEOUT_ERR;

  modport master (
    input  START, OUT_ACK, OUT_DATA, RD_READY,
    output OUT_REQ, RD_DATA, RD_VALID, BUSY, TIMEOUT_ERR
  );

  modport slave (
    output START, OUT_ACK, OUT_DATA, RD_READY,
    input  OUT_REQ, RD_DATA, RD_VALID, BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/rnn_out_reader.sv
// rtl/rnn_out_reader.sv - requests, deserialises and presents one RNN output word (LSB first).
// Optional REQ-state timeout abort is built only with RNN_RD_TIMEOUT_EN defined.
module rnn_out_reader #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic            CLK,
  input  logic            RSTB,
  rnn_out_reader_if.master bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("rnn_out_reader: WIDTH must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rnn_out_reader: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, SHIFT, HOLD} state_t;

  state_t           state, state_d;
  logic             out_req, out_req_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic [WIDTH-1:0] rd_data, rd_data_d;
  logic             rd_valid, rd_valid_d;
  logic             timeout_err, timeout_err_d;
  logic [CW-1:0]    cnt, cnt_d;

`ifdef RNN_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_d;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state       <= IDLE;
      out_req     <= 1'b0;
      shift       <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
`ifdef RNN_RD_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      state       <= state_d;
      out_req     <= out_req_d;
      shift       <= shift_d;
      rd_data     <= rd_data_d;
      rd_valid    <= rd_valid_d;
      timeout_err <= timeout_err_d;
      cnt         <= cnt_d;
`ifdef RNN_RD_TIMEOUT_EN
      tcnt        <= tcnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state;
    out_req_d     = out_req;
    shift_d       = shift;
    rd_data_d     = rd_data;
    rd_valid_d    = rd_valid;
    timeout_err_d = 1'b0;
    cnt_d         = cnt;
`ifdef RNN_RD_TIMEOUT_EN
    tcnt_d        = tcnt;
`endif
    case (state)
      IDLE: begin
        if (bus.START) begin
          state_d   = REQ;
          out_req_d = 1'b1;
`ifdef RNN_RD_TIMEOUT_EN
          tcnt_d    = '0;
`endif
        end
      end
      REQ: begin
        // ACK also carries bit 0, and beats the timeout on the same edge
        if (bus.OUT_ACK) begin
          shift_d[0] = bus.OUT_DATA;
          out_req_d  = 1'b0;
          cnt_d      = CW'(1);
          state_d    = SHIFT;
        end
`ifdef RNN_RD_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          out_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
`endif
      end
      SHIFT: begin
        shift_d[cnt] = bus.OUT_DATA;
        cnt_d        = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          rd_data_d  = shift_d;
          rd_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (rd_valid && bus.RD_READY) begin
          rd_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.OUT_REQ     = out_req;
  assign bus.RD_DATA     = rd_data;
  assign bus.RD_VALID    = rd_valid;
  assign bus.TIMEOUT_ERR = timeout_err;
  assign bus.BUSY        = (state != IDLE);

endmodule

// File: tb/tb_rnn_out_reader.sv
// tb/tb_rnn_out_reader.sv - self-checking bench for rnn_out_reader (WIDTH=8, TIMEOUT=16).
module tb_rnn_out_reader;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RSTB;

  rnn_out_reader_if #(.WIDTH(W)) bus ();

  rnn_out_reader #(.WIDTH(W), .TIMEOUT(16)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int n_words = 0;
  int n_pushed = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] sb_exp;
  logic [W-1:0] last_word;
  logic prev_valid = 1'b0;
  bit tie_ready = 1'b0;

  // Each (seq) lists bits in transmit order, first-sent bit leftmost
  typedef struct {
    logic [W-1:0] seq;
    logic [W-1:0] exp;
    int           delay;
    int           hold;
    bit           spur;
  } vec_t;
  vec_t vecs[3];

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (RSTB === 1'b1 && bus.RD_VALID === 1'b1 && !prev_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_unexpected_word", int'(bus.RD_DATA), -1);
      end else begin
        sb_exp = sb.pop_front();
        check_val("sb_data", int'(bus.RD_DATA), int'(sb_exp));
        n_words++;
      end
    end
    prev_valid <= (bus.RD_VALID === 1'b1);
  end

  task automatic transfer(input logic [W-1:0] seq, input logic [W-1:0] exp,
                          input int delay, input int hold, input bit spur);
    int bad;
    int early;
    sb.push_back(exp);
    n_pushed++;
    bus.RD_READY = tie_ready;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_bit("req_after_start", bus.OUT_REQ, 1'b1);
    check_bit("busy_after_start", bus.BUSY, 1'b1);
    bad = 0;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (bus.OUT_REQ !== 1'b1 || bus.TIMEOUT_ERR !== 1'b0) bad++;
    end
    check_val("req_wait_bad_cycles", bad, 0);
    bus.OUT_ACK = 1'b1;
    bus.OUT_DATA = seq[W-1];
    tick();
    bus.OUT_ACK = 1'b0;
    check_bit("req_low_after_ack", bus.OUT_REQ, 1'b0);
    early = 0;
    for (int k = 1; k < W; k++) begin
      bus.OUT_DATA = seq[W-1-k];
      if (bus.RD_VALID !== 1'b0 || bus.OUT_REQ !== 1'b0) early++;
      tick();
    end
    check_val("shift_early_valid_or_req", early, 0);
    check_bit("valid_at_latency", bus.RD_VALID, 1'b1);
    check_val("rd_data_at_latency", int'(bus.RD_DATA), int'(exp));
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      bus.RD_READY = 1'b0;
      if (spur) begin
        bus.OUT_ACK  = h[0];
        bus.OUT_DATA = ~seq[h % W];
        bus.START    = (h == 1);
      end
      tick();
      if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== exp || bus.OUT_REQ !== 1'b0) bad++;
    end
    check_val("hold_bad_cycles", bad, 0);
    bus.OUT_ACK = 1'b0;
    bus.START = 1'b0;
    bus.RD_READY = 1'b1;
    tick();
    bus.RD_READY = tie_ready;
    check_bit("valid_after_accept", bus.RD_VALID, 1'b0);
    check_bit("busy_after_accept", bus.BUSY, 1'b0);
    check_bit("req_after_accept", bus.OUT_REQ, 1'b0);
    check_val("rd_data_kept", int'(bus.RD_DATA), int'(exp));
    last_word = exp;
  endtask

  initial begin
    int bad;
    logic [W-1:0] part;
    vecs[0] = '{seq: 8'b10100101, exp: 8'hA5, delay: 3, hold: 0, spur: 1'b0};
    vecs[1] = '{seq: 8'b00111100, exp: 8'h3C, delay: 1, hold: 5, spur: 1'b1};
    vecs[2] = '{seq: 8'b01001000, exp: 8'h12, delay: 0, hold: 2, spur: 1'b0};

    RSTB = 1'b0;
    bus.START = 1'b0;
    bus.OUT_ACK = 1'b0;
    bus.OUT_DATA = 1'b0;
    bus.RD_READY = 1'b0;
    tick();
    tick();
    check_bit("rst_out_req", bus.OUT_REQ, 1'b0);
    check_bit("rst_rd_valid", bus.RD_VALID, 1'b0);
    check_val("rst_rd_data", int'(bus.RD_DATA), 0);
    check_bit("rst_busy", bus.BUSY, 1'b0);
    check_bit("rst_timeout_err", bus.TIMEOUT_ERR, 1'b0);
    RSTB = 1'b1;
    tick();

    foreach (vecs[i])
      transfer(vecs[i].seq, vecs[i].exp, vecs[i].delay, vecs[i].hold, vecs[i].spur);

    // Reset after four bits of 0xC3 have been captured
    part = 8'b11000011;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.OUT_ACK = 1'b1;
    bus.OUT_DATA = part[W-1];
    tick();
    bus.OUT_ACK = 1'b0;
    for (int k = 1; k < 4; k++) begin
      bus.OUT_DATA = part[W-1-k];
      tick();
    end
    RSTB = 1'b0;
    tick();
    RSTB = 1'b1;
    check_bit("midrst_out_req", bus.OUT_REQ, 1'b0);
    check_bit("midrst_rd_valid", bus.RD_VALID, 1'b0);
    check_val("midrst_rd_data", int'(bus.RD_DATA), 0);
    check_bit("midrst_busy", bus.BUSY, 1'b0);
    tick();
    transfer(8'b11000011, 8'hC3, 2, 0, 1'b0);

`ifdef RNN_RD_TIMEOUT_EN
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (bus.OUT_REQ !== 1'b1 || bus.TIMEOUT_ERR !== 1'b0) bad++;
    end
    check_val("to_pre_expiry_bad", bad, 0);
    tick();
    check_bit("to_out_req", bus.OUT_REQ, 1'b0);
    check_bit("to_err_pulse", bus.TIMEOUT_ERR, 1'b1);
    check_bit("to_busy", bus.BUSY, 1'b0);
    check_bit("to_rd_valid", bus.RD_VALID, 1'b0);
    check_val("to_rd_data", int'(bus.RD_DATA), int'(last_word));
    tick();
    check_bit("to_err_one_cycle", bus.TIMEOUT_ERR, 1'b0);
    transfer(8'b10000001, 8'h81, 15, 0, 1'b0);
    check_bit("to_ack_wins_no_err", bus.TIMEOUT_ERR, 1'b0);
`else
    transfer(8'b01011010, 8'h5A, 1000, 0, 1'b0);
    check_bit("nto_err_zero", bus.TIMEOUT_ERR, 1'b0);
`endif

    tie_ready = 1'b1;
    transfer(8'b11111111, 8'hFF, 0, 0, 1'b0);
    transfer(8'b00000000, 8'h00, 0, 0, 1'b0);
    tie_ready = 1'b0;
    bus.RD_READY = 1'b0;

    tick();
    tick();
    check_val("sb_empty", sb.size(), 0);
    check_val("word_count", n_words, n_pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
